// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 64-way mux: walks an inclusive, wrapping index range,
// drives the mux select, captures each selected word and streams it out with
// its index over a valid/ready interface.
module mux_scan_sequencer #(
    parameter int N      = 1,
    parameter int SETTLE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [5:0]   first,
    input  logic [5:0]   last,
    output logic [5:0]   mux_sel,
    input  logic [N-1:0] mux_data,
    output logic [N-1:0] out_data,
    output logic [5:0]   out_index,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_OUT    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // State entered whenever a new select value is applied.
    localparam state_t     SEL_ENTRY   = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t         state_q, state_d;
    logic [5:0]     cur_q, cur_d;      // current index, doubles as the registered mux select
    logic [5:0]     last_q, last_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   data_q, data_d;
    logic [5:0]     idx_q, idx_d;
    logic           vld_q, vld_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Next-state and next-output logic; abort overrides all scan progress.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        vld_d   = vld_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_d   = first;
                        last_d  = last;
                        cnt_d   = 4'd0;
                        state_d = SEL_ENTRY;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    data_d  = mux_data;
                    idx_d   = cur_q;
                    vld_d   = 1'b1;
                    state_d = S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        vld_d = 1'b0;
                        if (cur_q == last_q) begin
                            state_d = S_DONE;
                        end else begin
                            cur_d   = cur_q + 6'd1;
                            cnt_d   = 4'd0;
                            state_d = SEL_ENTRY;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= 6'd0;
            last_q  <= 6'd0;
            cnt_q   <= 4'd0;
            data_q  <= '0;
            idx_q   <= 6'd0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mux_sel   = cur_q;
    assign out_data  = data_q;
    assign out_index = idx_q;
    assign out_valid = vld_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE=0 and SETTLE=3), each
// fed by a lookup-table mux, checked against an expected word list and
// arithmetic timing derived from the range and settle setting.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_s [2];
    logic       abort_s [2];
    logic       ready_s [2];
    logic [5:0] first_s [2];
    logic [5:0] last_s  [2];
    logic [5:0] sel_s   [2];
    logic [7:0] mdat_s  [2];
    logic [7:0] dat_s   [2];
    logic [5:0] idx_s   [2];
    logic       vld_s   [2];
    logic       busy_s  [2];
    logic       done_s  [2];

    logic [7:0] tbl [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural 64-way mux: combinational table lookup on the select.
    always_comb begin
        mdat_s[0] = tbl[sel_s[0]];
        mdat_s[1] = tbl[sel_s[1]];
    end

    mux_scan_sequencer #(.N(8), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
        .first(first_s[0]), .last(last_s[0]), .mux_sel(sel_s[0]),
        .mux_data(mdat_s[0]), .out_data(dat_s[0]), .out_index(idx_s[0]),
        .out_valid(vld_s[0]), .out_ready(ready_s[0]), .busy(busy_s[0]),
        .done(done_s[0])
    );

    mux_scan_sequencer #(.N(8), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
        .first(first_s[1]), .last(last_s[1]), .mux_sel(sel_s[1]),
        .mux_data(mdat_s[1]), .out_data(dat_s[1]), .out_index(idx_s[1]),
        .out_valid(vld_s[1]), .out_ready(ready_s[1]), .busy(busy_s[1]),
        .done(done_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input int d, input string tag);
        chk({tag, "_sel"},  32'(sel_s[d]),  32'd0);
        chk({tag, "_data"}, 32'(dat_s[d]),  32'd0);
        chk({tag, "_idx"},  32'(idx_s[d]),  32'd0);
        chk({tag, "_vld"},  32'(vld_s[d]),  32'd0);
        chk({tag, "_busy"}, 32'(busy_s[d]), 32'd0);
        chk({tag, "_done"}, 32'(done_s[d]), 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One scan on instance d. rdy_pct: chance of ready per valid cycle;
    // stall_n: word number held off for 5 cycles (-1 none);
    // abort_n: word number during which abort is raised (-1 none).
    task automatic run_scan(input int d, input logic [5:0] f, input logic [5:0] l,
                            input int rdy_pct, input int stall_n, input int abort_n);
        int s;
        int cnt;
        int n;
        int cyc;
        int exp_at;
        int stall;
        bit in_word;
        bit r;
        logic [5:0] eidx [$];
        logic [7:0] edat [$];

        s   = (d == 0) ? 0 : 3;
        cnt = ((int'(l) - int'(f) + 64) % 64) + 1;
        for (int k = 0; k < cnt; k++) begin
            eidx.push_back(6'((int'(f) + k) % 64));
            edat.push_back(tbl[(int'(f) + k) % 64]);
        end

        @(negedge clk);
        start_s[d] = 1'b1;
        first_s[d] = f;
        last_s[d]  = l;
        ready_s[d] = 1'b0;
        @(negedge clk);
        start_s[d] = 1'b0;
        first_s[d] = 6'($urandom);
        last_s[d]  = 6'($urandom);
        chk("start_busy", 32'(busy_s[d]), 32'd1);
        chk("start_sel", 32'(sel_s[d]), 32'(f));

        cyc     = 1;
        n       = 0;
        exp_at  = 2 + s;
        stall   = 0;
        in_word = 1'b0;
        while (n < cnt && cyc < 4000 && errors < 40) begin
            if (!in_word) chk("vld_timing", 32'(vld_s[d]), 32'(cyc >= exp_at));
            chk("scan_busy", 32'(busy_s[d]), 32'd1);
            chk("scan_done", 32'(done_s[d]), 32'd0);
            if (vld_s[d]) begin
                in_word = 1'b1;
                chk("word_idx", 32'(idx_s[d]), 32'(eidx[n]));
                chk("word_data", 32'(dat_s[d]), 32'(edat[n]));
                chk("sel_hold", 32'(sel_s[d]), 32'(eidx[n]));
                if (n == abort_n) begin
                    ready_s[d] = 1'b0;
                    abort_s[d] = 1'b1;
                    @(negedge clk);
                    abort_s[d] = 1'b0;
                    chk("abort_vld", 32'(vld_s[d]), 32'd0);
                    chk("abort_busy", 32'(busy_s[d]), 32'd0);
                    chk("abort_sel", 32'(sel_s[d]), 32'(eidx[n]));
                    for (int i = 0; i < 3; i++) begin
                        chk("abort_done", 32'(done_s[d]), 32'd0);
                        chk("abort_idle", 32'(busy_s[d]), 32'd0);
                        @(negedge clk);
                    end
                    return;
                end
                if (n == stall_n && stall < 5) begin
                    r = 1'b0;
                    stall++;
                end else begin
                    r = ($urandom_range(99) < rdy_pct);
                end
                ready_s[d] = r;
                if (r) begin
                    n++;
                    exp_at  = cyc + 2 + s;
                    in_word = 1'b0;
                end
            end else begin
                ready_s[d] = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end

        if (n != cnt) begin
            chk("scan_words", 32'(n), 32'(cnt));
            pulse_rst();
            return;
        end

        // DONE cycle: a start here must be ignored.
        ready_s[d] = 1'b0;
        chk("done_pulse", 32'(done_s[d]), 32'd1);
        chk("done_busy", 32'(busy_s[d]), 32'd1);
        chk("done_vld", 32'(vld_s[d]), 32'd0);
        start_s[d] = 1'b1;
        first_s[d] = 6'(int'(l) + 7);
        last_s[d]  = 6'(int'(l) + 9);
        @(negedge clk);
        start_s[d] = 1'b0;
        chk("post_done", 32'(done_s[d]), 32'd0);
        chk("post_busy", 32'(busy_s[d]), 32'd0);
        chk("post_sel", 32'(sel_s[d]), 32'(l));
        @(negedge clk);
        chk("ignored_start_busy", 32'(busy_s[d]), 32'd0);
        chk("ignored_start_vld", 32'(vld_s[d]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            abort_s[i] = 1'b0;
            ready_s[i] = 1'b0;
            first_s[i] = 6'd0;
            last_s[i]  = 6'd0;
        end
        for (int k = 0; k < 64; k++) tbl[k] = 8'(k + 8'h40);

        // Reset then idle.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle_zero(0, "rst0");
        chk_idle_zero(1, "rst1");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_vld", 32'(vld_s[0]), 32'd0);
            chk("idle_sel", 32'(sel_s[0]), 32'd0);
        end

        // Basic, wrap, full sweep, backpressure.
        run_scan(0, 6'd3, 6'd6, 100, -1, -1);
        run_scan(0, 6'd62, 6'd1, 100, -1, -1);
        for (int k = 0; k < 64; k++) tbl[k] = 8'($urandom);
        run_scan(0, 6'd10, 6'd9, 100, -1, -1);
        run_scan(0, 6'd0, 6'd9, 100, 4, -1);

        // Abort mid-scan, then a one-word scan.
        run_scan(0, 6'd0, 6'd7, 100, -1, 2);
        run_scan(0, 6'd5, 6'd5, 100, -1, -1);

        // Randomised ranges and backpressure.
        for (int t = 0; t < 6; t++) begin
            logic [5:0] f;
            logic [5:0] l;
            f = 6'($urandom);
            l = 6'(int'(f) + $urandom_range(20));
            run_scan(0, f, l, 60, -1, -1);
        end

        // Settle instance.
        run_scan(1, 6'd3, 6'd6, 100, -1, -1);
        run_scan(1, 6'd60, 6'd2, 50, 1, -1);
        run_scan(1, 6'd8, 6'd12, 100, -1, 3);

        // Reset during SETTLE.
        @(negedge clk);
        start_s[1] = 1'b1;
        first_s[1] = 6'd20;
        last_s[1]  = 6'd25;
        @(negedge clk);
        start_s[1] = 1'b0;
        chk("settle_busy", 32'(busy_s[1]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero(1, "rst_settle");
        repeat (6) @(negedge clk);
        chk("rst_settle_stays", 32'(busy_s[1]), 32'd0);
        chk("rst_settle_novld", 32'(vld_s[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
